// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: addresses instruction memory, captures into the IR, hands off to decode.
// Optional performance counters (fetch_count, squash_count) are built when FETCH_SEQ_PERF_CNT_EN is defined.
module fetch_sequencer #(
  parameter int                ADDR_W      = 4,
  parameter int                INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = 4'b1111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_instr,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               busy,
  output logic               halted,
`ifdef FETCH_SEQ_PERF_CNT_EN
  output logic [7:0]         fetch_count,
  output logic [7:0]         squash_count,
`endif
  output logic [1:0]         state_dbg
);

  // Handshake: the IR moves to decode on any rising edge where ir_valid & ir_ready.
  // While ir_valid & !ir_ready, ir_instr and ir_pc are held unchanged.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [ADDR_W-1:0]    pc, pc_n;
  logic                 ir_valid_n;
  logic [INSTR_W-1:0]   ir_instr_n;
  logic [ADDR_W-1:0]    ir_pc_n;
  logic                 slot_free;
  logic                 xfer;
  logic                 restart;
  logic                 squash;

  assign slot_free = !ir_valid || ir_ready;
  assign xfer      = ir_valid && ir_ready;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_valid_n = ir_valid;
    ir_instr_n = ir_instr;
    ir_pc_n    = ir_pc;
    restart    = 1'b0;
    squash     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = FETCH;
          pc_n       = RESET_PC;
          ir_valid_n = 1'b0;
          restart    = 1'b1;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          // A transfer in this same cycle has already been delivered; only an untransferred IR is lost.
          pc_n       = redirect_pc;
          ir_valid_n = 1'b0;
          squash     = ir_valid && !ir_ready;
        end else if (slot_free) begin
          ir_instr_n = imem_instr;
          ir_pc_n    = pc;
          ir_valid_n = 1'b1;
          pc_n       = pc + 1'b1;
          if (imem_instr[INSTR_W-1 -: 4] == HALT_OPCODE) state_n = HALT;
        end
      end
      HALT: begin
        if (start) begin
          state_n    = FETCH;
          pc_n       = RESET_PC;
          ir_valid_n = 1'b0;
          restart    = 1'b1;
        end else if (xfer) begin
          ir_valid_n = 1'b0;
        end
      end
      default: begin
        state_n    = IDLE;
        ir_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir_valid <= 1'b0;
      ir_instr <= '0;
      ir_pc    <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir_valid <= ir_valid_n;
      ir_instr <= ir_instr_n;
      ir_pc    <= ir_pc_n;
    end
  end

`ifdef FETCH_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      fetch_count  <= 8'd0;
      squash_count <= 8'd0;
    end else begin
      if (xfer)   fetch_count  <= fetch_count + 8'd1;
      if (squash) squash_count <= squash_count + 8'd1;
    end
  end
`endif

  assign imem_addr = pc;
  assign busy      = (state == FETCH);
  assign halted    = (state == HALT) && !ir_valid;
  assign state_dbg = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: straight-line fetch, backpressure, redirect, wrap, HALT drain, reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_instr;
  logic [3:0]  ir_pc;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        busy;
  logic        halted;
  logic [1:0]  state_dbg;
`ifdef FETCH_SEQ_PERF_CNT_EN
  logic [7:0]  fetch_count;
  logic [7:0]  squash_count;
`endif

  logic [15:0] mem [16];
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  assign imem_instr = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_instr       (ir_instr),
    .ir_pc          (ir_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .halted         (halted),
`ifdef FETCH_SEQ_PERF_CNT_EN
    .fetch_count    (fetch_count),
    .squash_count   (squash_count),
`endif
    .state_dbg      (state_dbg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1045; mem[1] = 16'h6057; mem[2] = 16'h0000; mem[3] = 16'hF000;
    mem[7] = 16'h3077;
    rst_n = 1'b0; start = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 4'd0;

    // Reset state
    step(); step();
    check("rst_ir_valid", ir_valid, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_state", state_dbg, 0);
    check("rst_ir_instr", ir_instr, 0);
    check("rst_ir_pc", ir_pc, 0);
    rst_n = 1'b1;
    step();

    // Straight-line fetch to HALT
    exp_q.push_back(16'h1045); exp_q.push_back(16'h6057);
    exp_q.push_back(16'h0000); exp_q.push_back(16'hF000);
    start = 1'b1; ir_ready = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ir_valid", ir_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("line_valid", ir_valid, 1);
      check("line_instr", ir_instr, exp_q.pop_front());
      check("line_pc", ir_pc, i);
    end
    check("line_halt_busy", busy, 0);
    check("line_halt_pending", halted, 0);
    step();
    check("line_end_valid", ir_valid, 0);
    check("line_end_halted", halted, 1);
    check("line_end_busy", busy, 0);

    // Backpressure
    start = 1'b1; ir_ready = 1'b0;
    step();
    start = 1'b0;
`ifdef FETCH_SEQ_PERF_CNT_EN
    check("start_clr_fetch", fetch_count, 0);
`endif
    step();
    check("bp_first_valid", ir_valid, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_instr", ir_instr, 16'h1045);
      check("bp_hold_pc", ir_pc, 0);
      check("bp_hold_addr", imem_addr, 1);
      check("bp_hold_valid", ir_valid, 1);
    end
    ir_ready = 1'b1;
    step();
    check("bp_release_instr", ir_instr, 16'h6057);
    check("bp_release_pc", ir_pc, 1);

    // Redirect squashing an untransferred IR
    step();
    check("rd_pre_pc", ir_pc, 2);
    redirect_valid = 1'b1; redirect_pc = 4'd7; ir_ready = 1'b0;
    step();
    redirect_valid = 1'b0; ir_ready = 1'b1;
    check("rd_squash_valid", ir_valid, 0);
    check("rd_addr", imem_addr, 7);
    step();
    check("rd_target_pc", ir_pc, 7);
    check("rd_target_instr", ir_instr, 16'h3077);
`ifdef FETCH_SEQ_PERF_CNT_EN
    check("rd_squash_count", squash_count, 1);
    check("rd_fetch_count", fetch_count, 2);
`endif

    // Wrap-around 15 -> 0
    mem[15] = 16'h1000; mem[0] = 16'h2000;
    redirect_valid = 1'b1; redirect_pc = 4'd15;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr", imem_addr, 15);
    step();
    check("wrap_pc15", ir_pc, 15);
    check("wrap_instr15", ir_instr, 16'h1000);
    check("wrap_addr0", imem_addr, 0);
    step();
    check("wrap_pc0", ir_pc, 0);
    check("wrap_instr0", ir_instr, 16'h2000);

    // HALT drain, redirect ignored in HALT, restart
    redirect_valid = 1'b1; redirect_pc = 4'd3;
    step();
    redirect_valid = 1'b0; ir_ready = 1'b0;
    step();
    check("halt_state", state_dbg, 2);
    check("halt_pending", halted, 0);
    step();
    check("halt_hold_instr", ir_instr, 16'hF000);
    check("halt_hold_pc", ir_pc, 3);
    check("halt_still_pending", halted, 0);
    redirect_valid = 1'b1; redirect_pc = 4'd9; ir_ready = 1'b1;
    step();
    check("halt_drained", halted, 1);
    check("halt_addr", imem_addr, 4);
    redirect_valid = 1'b0;
    step();
    check("halt_addr_stable", imem_addr, 4);
    check("halt_stays", halted, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_addr", imem_addr, 0);
`ifdef FETCH_SEQ_PERF_CNT_EN
    check("restart_clr_squash", squash_count, 0);
`endif
    step();
    check("restart_pc", ir_pc, 0);
    check("restart_instr", ir_instr, 16'h2000);

    // Reset mid-stream, then IDLE behaviour
    ir_ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; ir_ready = 1'b1;
    check("mrst_valid", ir_valid, 0);
    check("mrst_addr", imem_addr, 0);
    check("mrst_state", state_dbg, 0);
    redirect_valid = 1'b1; redirect_pc = 4'd5;
    step();
    redirect_valid = 1'b0;
    check("idle_redirect_addr", imem_addr, 0);
    check("idle_redirect_state", state_dbg, 0);
    step();
    check("idle_no_fetch", ir_valid, 0);
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 4'd5;
    step();
    start = 1'b0; redirect_valid = 1'b0;
    check("start_wins_addr", imem_addr, 0);
    check("start_wins_busy", busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch controller for the 16x16 instruction memory.
- Drives the memory address and captures the combinational read data into an instruction register (IR).
- Presents the IR to decode through a valid/ready handshake; accepts branch/jump redirects; stops on a HALT opcode.
- Sits between instruction_memory and the decode/control stage of the RISC CPU.

Parameters:
- ADDR_W, 4, PC / instruction-memory address width.
- INSTR_W, 16, instruction width; opcode = instr[INSTR_W-1:INSTR_W-4].
- RESET_PC, 0, PC loaded on start.
- HALT_OPCODE, 4'b1111, opcode that terminates fetching.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin fetching at RESET_PC (pulse)
- imem_addr  output  ADDR_W  address to instruction memory; equals pc register
- imem_instr  input  INSTR_W  combinational read data from instruction memory
- ir_valid  output  1  IR holds an instruction for decode
- ir_ready  input  1  decode accepts IR this cycle
- ir_instr  output  INSTR_W  instruction register
- ir_pc  output  ADDR_W  address the IR instruction was fetched from
- redirect_valid  input  1  branch/jump taken; flush and refetch
- redirect_pc  input  ADDR_W  redirect target
- busy  output  1  state is FETCH
- halted  output  1  HALT fetched and IR drained

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is synchronous, active-low, sampled on rising clk.
  - While rst_n=0 at an edge: state=IDLE, pc=RESET_PC, ir_valid=0, ir_instr=0, ir_pc=0, busy=0, halted=0.
  - Reset mid-operation discards the IR and any pending redirect.
- imem_addr = pc (registered, no combinational path from inputs).
- Slot free: free = !ir_valid | ir_ready. A handshake (transfer) occurs when ir_valid & ir_ready.
- States: IDLE, FETCH, HALT.
- IDLE:
  - start -> FETCH, pc=RESET_PC.
  - redirect_valid is ignored.
  - start and redirect_valid together: start wins.
- FETCH, priority high to low:
  1. redirect_valid:
     - pc<=redirect_pc and ir_valid<=0 (IR squashed); no capture this cycle.
     - A transfer in the same cycle still counts as delivered.
  2. free: ir_instr<=imem_instr, ir_pc<=pc, ir_valid<=1, pc<=pc+1 modulo 2^ADDR_W (15 -> 0 wraps).
     - If the captured opcode == HALT_OPCODE -> HALT; pc is still incremented.
  3. Otherwise (ir_valid & !ir_ready): hold IR and pc unchanged (stall).
- HALT:
  - No further captures; the HALT instruction stays in the IR until transferred, then ir_valid<=0.
  - redirect_valid is ignored.
  - halted = (state==HALT) & !ir_valid.
  - start -> FETCH, pc=RESET_PC; ir_valid<=0, dropping any undelivered IR.
- busy = (state==FETCH).
- Throughput: one instruction per cycle while ir_ready=1.
- Latency: start sampled at edge N; ir_valid=1 with mem[RESET_PC] after edge N+1; after a redirect at edge M, the target instruction is valid after edge M+1.
- ir_instr/ir_pc must stay stable while ir_valid & !ir_ready.

Optional Feature:
- Macro: FETCH_SEQ_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count [7:0], which increments on every transfer and wraps 255 -> 0.
  - Adds output squash_count [7:0], which increments when redirect_valid in FETCH squashes a valid, untransferred IR; it wraps 255 -> 0.
  - Both clear on reset and on start.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Straight-line fetch: mem[0..3]=16'h1045,16'h6057,16'h0000,16'hF000; reset, start pulse, ir_ready=1 -> ir_instr 1045,6057,0000,F000 on consecutive cycles with ir_pc 0,1,2,3; then ir_valid=0, halted=1, busy=0.
- Backpressure: ir_ready=0 for 3 cycles after the first capture -> ir_instr=mem[0], ir_pc=0 held stable and imem_addr=1 held; on release, mem[1] follows on the next cycle.
- Redirect: redirect_valid=1 with redirect_pc=7 while the IR holds pc 2 -> next cycle ir_valid=0 and imem_addr=7; following cycle ir_pc=7, ir_instr=mem[7]; with the macro defined, squash_count=1.
- Wrap-around: redirect to 15 with mem[15]=16'h1000 and mem[0]=16'h2000 -> ir_pc sequence 15, 0 with the matching instructions.
- HALT drain and restart: HALT fetched with ir_ready=0 -> halted=0 until the handshake, 1 afterwards; redirect_valid while in HALT has no effect; start -> ir_pc=0 two cycles later.
- Reset mid-stream: rst_n=0 for one edge while ir_valid=1 -> ir_valid=0, imem_addr=0, state IDLE; no fetch until start.
